// File: rtl/comparator_track_nbit.sv
// Registered a/b magnitude comparator with equal-event counter and optional min/max tracking of a.
// Min/max tracking is compiled in only when CMP_MINMAX_TRACK_EN is defined.
module comparator_track_nbit #(
  parameter int unsigned N      = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             clear,
  output logic             out_valid,
  output logic             smaller,
  output logic             equal,
  output logic             greater,
  output logic [CNT_W-1:0] eq_count,
  output logic [N-1:0]     min_a,
  output logic [N-1:0]     max_a,
  output logic             stats_valid
);

  // Flipping the MSB maps two's-complement order onto unsigned order.
  localparam logic [N-1:0] KeyFlip = (SIGNED != 0) ? {1'b1, {(N-1){1'b0}}} : '0;

  logic [N-1:0] a_key, b_key;
  logic         a_lt, a_eq, a_gt;

  assign a_key = a ^ KeyFlip;
  assign b_key = b ^ KeyFlip;
  assign a_lt  = a_key < b_key;
  assign a_eq  = a == b;
  assign a_gt  = a_key > b_key;

  logic             out_valid_q;
  logic             smaller_q, equal_q, greater_q;
  logic [CNT_W-1:0] eq_count_q, eq_count_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      smaller_q   <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        smaller_q <= a_lt;
        equal_q   <= a_eq;
        greater_q <= a_gt;
      end
    end
  end

  always_comb begin
    eq_count_d = eq_count_q;
    if (clear) begin
      eq_count_d = (in_valid && a_eq) ? CNT_W'(1) : '0;
    end else if (in_valid && a_eq && (eq_count_q != '1)) begin
      eq_count_d = eq_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eq_count_q <= '0;
    end else begin
      eq_count_q <= eq_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign smaller   = smaller_q;
  assign equal     = equal_q;
  assign greater   = greater_q;
  assign eq_count  = eq_count_q;

`ifdef CMP_MINMAX_TRACK_EN
  typedef enum logic [0:0] {StEmpty, StTrack} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] min_q, min_d, max_q, max_d;
  logic [N-1:0] min_key, max_key;

  assign min_key = min_q ^ KeyFlip;
  assign max_key = max_q ^ KeyFlip;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    if (clear && !in_valid) begin
      state_d = StEmpty;
      min_d   = '0;
      max_d   = '0;
    end else if (in_valid) begin
      // A clear alongside a sample restarts tracking from that sample.
      if (clear || (state_q == StEmpty)) begin
        state_d = StTrack;
        min_d   = a;
        max_d   = a;
      end else begin
        if (a_key < min_key) min_d = a;
        if (a_key > max_key) max_d = a;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign min_a       = min_q;
  assign max_a       = max_q;
  assign stats_valid = (state_q == StTrack);
`else
  assign min_a       = '0;
  assign max_a       = '0;
  assign stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_comparator_track_nbit.sv
// Self-checking bench: unsigned and signed instances driven in parallel, checked against a
// history-based reference model plus directed vector table and corner sequences.
module tb_comparator_track_nbit;

  localparam int unsigned N     = 12;
  localparam int unsigned CNT_W = 3;
  localparam int          CMAX  = 7;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid, clear;
  logic [N-1:0] a, b;

  logic u_ov, u_sm, u_eq, u_gt, u_sv;
  logic s_ov, s_sm, s_eq, s_gt, s_sv;
  logic [CNT_W-1:0] u_cnt, s_cnt;
  logic [N-1:0] u_min, u_max, s_min, s_max;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  comparator_track_nbit #(.N(N), .SIGNED(0), .CNT_W(CNT_W)) dut_u (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .a(a), .b(b), .clear(clear),
    .out_valid(u_ov), .smaller(u_sm), .equal(u_eq), .greater(u_gt), .eq_count(u_cnt),
    .min_a(u_min), .max_a(u_max), .stats_valid(u_sv)
  );

  comparator_track_nbit #(.N(N), .SIGNED(1), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .a(a), .b(b), .clear(clear),
    .out_valid(s_ov), .smaller(s_sm), .equal(s_eq), .greater(s_gt), .eq_count(s_cnt),
    .min_a(s_min), .max_a(s_max), .stats_valid(s_sv)
  );

  // Reference model: raw history of a since the last clear, plus flag/count state.
  int         hist[$];
  int         m_cnt;
  logic [2:0] m_fu, m_fs;
  logic       m_ov;

`ifdef CMP_MINMAX_TRACK_EN
  localparam bit Track = 1'b1;
`else
  localparam bit Track = 1'b0;
`endif

  function automatic int key(input int v, input bit s);
    if (s && v >= 2048) return v - 4096;
    return v;
  endfunction

  function automatic logic [2:0] order(input int x, input int y, input bit s);
    int kx = key(x, s);
    int ky = key(y, s);
    return {kx < ky, x == y, kx > ky};
  endfunction

  function automatic int exp_ext(input bit s, input bit want_max);
    int best;
    if (!Track || hist.size() == 0) return 0;
    best = key(hist[0], s);
    foreach (hist[i]) begin
      if (want_max && key(hist[i], s) > best) best = key(hist[i], s);
      if (!want_max && key(hist[i], s) < best) best = key(hist[i], s);
    end
    return best & 'hFFF;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cnt = 0;
    m_fu  = '0;
    m_fs  = '0;
    m_ov  = 1'b0;
  endtask

  task automatic model_step();
    m_ov = in_valid;
    if (in_valid) begin
      m_fu = order(int'(a), int'(b), 1'b0);
      m_fs = order(int'(a), int'(b), 1'b1);
    end
    if (clear) begin
      hist.delete();
      m_cnt = 0;
    end
    if (in_valid) begin
      hist.push_back(int'(a));
      if (a == b && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("u_out_valid", 32'(u_ov), 32'(m_ov));
    chk("s_out_valid", 32'(s_ov), 32'(m_ov));
    chk("u_flags", 32'({u_sm, u_eq, u_gt}), 32'(m_fu));
    chk("s_flags", 32'({s_sm, s_eq, s_gt}), 32'(m_fs));
    chk("u_eq_count", 32'(u_cnt), 32'(m_cnt));
    chk("s_eq_count", 32'(s_cnt), 32'(m_cnt));
    chk("u_min_a", 32'(u_min), 32'(exp_ext(1'b0, 1'b0)));
    chk("u_max_a", 32'(u_max), 32'(exp_ext(1'b0, 1'b1)));
    chk("s_min_a", 32'(s_min), 32'(exp_ext(1'b1, 1'b0)));
    chk("s_max_a", 32'(s_max), 32'(exp_ext(1'b1, 1'b1)));
    chk("u_stats_valid", 32'(u_sv), 32'(Track && hist.size() > 0));
    chk("s_stats_valid", 32'(s_sv), 32'(Track && hist.size() > 0));
  endtask

  task automatic step(input logic iv, input logic clr, input logic [N-1:0] av,
                      input logic [N-1:0] bv);
    in_valid = iv;
    clear    = clr;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   flags;   // {smaller, equal, greater}
    int           cnt;
    int           mn;
    int           mx;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{a: 12'd0,   b: 12'd0,  flags: 3'b010, cnt: 1, mn: 0, mx: 0};
    tbl[1] = '{a: 12'd5,   b: 12'd99, flags: 3'b100, cnt: 1, mn: 0, mx: 5};
    tbl[2] = '{a: 12'd66,  b: 12'd66, flags: 3'b010, cnt: 2, mn: 0, mx: 66};
    tbl[3] = '{a: 12'd100, b: 12'd47, flags: 3'b001, cnt: 2, mn: 0, mx: 100};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    a        = '0;
    b        = '0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Directed vector table from a clean start.
    step(1'b0, 1'b1, '0, '0);
    foreach (tbl[i]) begin
      step(1'b1, 1'b0, tbl[i].a, tbl[i].b);
      chk("tbl_flags", 32'({u_sm, u_eq, u_gt}), 32'(tbl[i].flags));
      chk("tbl_valid", 32'(u_ov), 32'd1);
      chk("tbl_eq_count", 32'(u_cnt), 32'(tbl[i].cnt));
      chk("tbl_min_a", 32'(u_min), Track ? 32'(tbl[i].mn) : 32'd0);
      chk("tbl_max_a", 32'(u_max), Track ? 32'(tbl[i].mx) : 32'd0);
    end

    // Idle cycle holds flags, drops out_valid.
    step(1'b0, 1'b0, 12'd1, 12'd2);
    chk("hold_valid", 32'(u_ov), 32'd0);
    chk("hold_flags", 32'({u_sm, u_eq, u_gt}), 32'b001);

    // Sign-aware ordering.
    step(1'b1, 1'b0, 12'hFFF, 12'd1);
    chk("unsigned_fff_gt", 32'({u_sm, u_eq, u_gt}), 32'b001);
    chk("signed_fff_lt", 32'({s_sm, s_eq, s_gt}), 32'b100);

    // Clear alone: stats zeroed, flags untouched.
    step(1'b0, 1'b1, '0, '0);
    chk("clear_flags_kept", 32'({s_sm, s_eq, s_gt}), 32'b100);
    chk("clear_cnt", 32'(u_cnt), 32'd0);
    chk("clear_sv", 32'(u_sv), 32'd0);

    // Counter saturation.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 12'd3, 12'd3);
      chk("sat_count", 32'(u_cnt), (i + 1 > CMAX) ? 32'(CMAX) : 32'(i + 1));
    end

    // Clear with sample after history min 3 / max 900.
    step(1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b0, 12'd3, 12'd5);
    step(1'b1, 1'b0, 12'd900, 12'd5);
    step(1'b1, 1'b0, 12'd500, 12'd500);
    chk("hist_min", 32'(u_min), Track ? 32'd3 : 32'd0);
    chk("hist_max", 32'(u_max), Track ? 32'd900 : 32'd0);
    step(1'b1, 1'b1, 12'd7, 12'd7);
    chk("restart_min", 32'(u_min), Track ? 32'd7 : 32'd0);
    chk("restart_max", 32'(u_max), Track ? 32'd7 : 32'd0);
    chk("restart_cnt", 32'(u_cnt), 32'd1);
    chk("restart_sv", 32'(u_sv), 32'(Track));

    // Asynchronous reset mid-stream with a sample in flight.
    step(1'b1, 1'b0, 12'd10, 12'd20);
    in_valid = 1'b1;
    a        = 12'd11;
    b        = 12'd11;
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_valid", 32'(u_ov), 32'd0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    step(1'b1, 1'b0, 12'd40, 12'd2);
    chk("post_rst_flags", 32'({u_sm, u_eq, u_gt}), 32'b001);
    chk("post_rst_min", 32'(u_min), Track ? 32'd40 : 32'd0);
    chk("post_rst_max", 32'(u_max), Track ? 32'd40 : 32'd0);
    chk("post_rst_cnt", 32'(u_cnt), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
